regfile_read_arbiter: RTL and testbench
=======================================

REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3: number of requesters sharing one register-file read port (2..8).
REQ-002 SHALL have parameter ZERO_REG, default 31: register index that reads as zero (XZR).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req, input, NREQ: per-requester read request.
REQ-006 SHALL have port req_addr, input, NREQ x 5: per-requester register index.
REQ-007 SHALL have port gnt, output, NREQ: one-hot grant, combinational, same cycle as req.
REQ-008 SHALL have port mux_addr, output, 5: select driven to the 32x64 read mux.
REQ-009 SHALL have port mux_data, input, 64: read mux output for mux_addr.
REQ-010 SHALL have port rsp_valid, output, NREQ: one-hot, registered response strobe.
REQ-011 SHALL have port rsp_data, output, 64: registered read data.
REQ-012 SHALL have port conflict_cnt, output, 16: saturating count of cycles with more than one req asserted.

Function
REQ-013 SHALL grant at most one requester per cycle; gnt SHALL be zero when req is zero.
REQ-014 SHALL arbitrate round-robin: search starts at index ptr, ascending with wrap NREQ-1 -> 0; first asserted req wins.
REQ-015 SHALL update ptr to (granted index + 1) mod NREQ on each grant cycle; ptr SHALL hold when no grant.
REQ-016 SHALL drive mux_addr = req_addr of granted requester; mux_addr SHALL be 0 when no grant.
REQ-017 SHALL register on the grant edge: rsp_valid = gnt, rsp_data = mux_data; latency req-to-rsp exactly 1 cycle.
REQ-018 SHALL force rsp_data to 0 when granted address equals ZERO_REG, regardless of mux_data.
REQ-019 SHALL clear rsp_valid in any cycle following a no-grant cycle; rsp_data SHALL hold its last value.
REQ-020 SHALL require requesters to hold req and req_addr stable until granted; ungranted requests carry no state inside the block.
REQ-021 SHALL guarantee any continuously asserted req is granted within NREQ cycles.
REQ-022 SHALL increment conflict_cnt when popcount(req) >= 2, saturating at 16'hFFFF with no wrap.
REQ-023 SHALL allow a requester to deassert req in the cycle after its grant and re-request later with no penalty beyond round-robin order.
REQ-024 SHALL treat a single asserted req as granted immediately regardless of ptr.

Reset
REQ-025 SHALL, while reset is high at a clock edge, set ptr = 0, rsp_valid = 0, rsp_data = 0, conflict_cnt = 0.
REQ-026 SHALL force gnt = 0 and mux_addr = 0 combinationally while reset is high.
REQ-027 SHALL discard a grant coinciding with reset assertion: no rsp_valid in the following cycle.
REQ-028 SHALL resume arbitration from ptr = 0 on the first cycle after reset deasserts.

Verification
REQ-029 SHALL pass: after reset, req=001, req_addr[0]=5, mux_data=64'hA5 -> gnt=001, mux_addr=5 same cycle; next cycle rsp_valid=001, rsp_data=64'hA5.
REQ-030 SHALL pass: NREQ=3, req=111 held 6 cycles -> gnt sequence 001,010,100,001,010,100; conflict_cnt=6.
REQ-031 SHALL pass: req=100 only, req_addr[2]=31, mux_data=64'hFFFF -> gnt=100; next cycle rsp_data=0, rsp_valid=100.
REQ-032 SHALL pass: ptr=2 (after granting 1), req=011 -> gnt=001 (wrap), ptr becomes 1.
REQ-033 SHALL pass: req=111 with reset high on cycle 3 -> gnt=000 during reset, rsp_valid=000 on cycle 4, conflict_cnt=0, first grant after release = 001.
REQ-034 SHALL pass: req=011 held 70000 cycles -> conflict_cnt stops at 16'hFFFF; grants strictly alternate 001/010.

Source files
------------

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter that shares one 32x64 register-file read port among NREQ requesters.
// The grant is combinational; the response strobe and read data are registered.
module regfile_read_arbiter #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ-1:0][4:0]      req_addr,
    output logic [NREQ-1:0]           gnt,
    output logic [4:0]                mux_addr,
    input  logic [63:0]               mux_data,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [63:0]               rsp_data,
    output logic [15:0]               conflict_cnt
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    logic          multi_req;
    logic          zero_hit;

    // Scan requesters starting at ptr, wrapping past NREQ-1 back to 0.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr_q} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
        if (reset) begin
            found = 1'b0;
        end
    end

    always_comb begin
        gnt      = '0;
        mux_addr = '0;
        ptr_d    = ptr_q;
        if (found) begin
            gnt[gnt_idx] = 1'b1;
            mux_addr     = req_addr[gnt_idx];
            ptr_d        = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    assign multi_req = (req & (req - NREQ'(1))) != '0;
    assign zero_hit  = mux_addr == 5'(ZERO_REG);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q        <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            conflict_cnt <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rsp_valid <= gnt;
            if (found) begin
                rsp_data <= zero_hit ? 64'd0 : mux_data;
            end
            if (multi_req && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Randomized and directed bench for regfile_read_arbiter (NREQ=3) against a
// behavioural round-robin model with a 32-entry register file.
module tb_regfile_read_arbiter;

    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [2:0]        req;
    logic [2:0][4:0]   req_addr;
    logic [2:0]        gnt;
    logic [4:0]        mux_addr;
    logic [63:0]       mux_data;
    logic [2:0]        rsp_valid;
    logic [63:0]       rsp_data;
    logic [15:0]       conflict_cnt;

    logic [63:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    int          m_ptr;
    logic [2:0]  m_rv;
    logic [63:0] m_rd;
    int          m_cnt;

    regfile_read_arbiter #(
        .NREQ     (NREQ),
        .ZERO_REG (31)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .gnt          (gnt),
        .mux_addr     (mux_addr),
        .mux_data     (mux_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    assign mux_data = rf[mux_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check combinational grant against the model, clock, check registers.
    task automatic tick();
        int          g;
        int          j;
        int          pc;
        logic [1:0]  gi;
        logic [2:0]  eg;
        logic [4:0]  ea;
        logic [63:0] ed;
        #1;
        g = -1;
        if (!reset) begin
            for (int k = 0; k < NREQ; k++) begin
                j  = (m_ptr + k) % NREQ;
                gi = j[1:0];
                if (g < 0 && req[gi]) g = j;
            end
        end
        eg = '0;
        ea = '0;
        ed = '0;
        if (g >= 0) begin
            gi     = g[1:0];
            eg[gi] = 1'b1;
            ea     = req_addr[gi];
            ed     = (ea == 5'd31) ? 64'd0 : rf[ea];
        end
        check("gnt", 64'(gnt), 64'(eg));
        check("mux_addr", 64'(mux_addr), 64'(ea));
        pc = $countones(req);
        @(posedge clk);
        #1;
        if (reset) begin
            m_ptr = 0;
            m_rv  = '0;
            m_rd  = '0;
            m_cnt = 0;
        end else begin
            if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                m_rd  = ed;
            end
            m_rv = eg;
            if (pc >= 2 && m_cnt < 65535) m_cnt++;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(m_rv));
        check("rsp_data", rsp_data, m_rd);
        check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        req      = '0;
        req_addr = '0;
        m_ptr    = 0;
        m_rv     = '0;
        m_rd     = '0;
        m_cnt    = 0;
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom};
        @(posedge clk);
        #1;
        tick();
        do_reset();

        // Single request after reset, data A5 from r5.
        rf[5]       = 64'hA5;
        req         = 3'b001;
        req_addr[0] = 5'd5;
        tick();
        check("r029_rsp_data", rsp_data, 64'hA5);
        req = '0;
        tick();

        // All three held: strict rotation, six conflict cycles.
        do_reset();
        req = 3'b111;
        repeat (6) tick();
        check("r030_cnt", 64'(conflict_cnt), 64'd6);

        // Zero register reads as 0 regardless of mux data.
        rf[31]      = 64'hFFFF;
        req         = 3'b100;
        req_addr[2] = 5'd31;
        tick();
        check("r031_rsp_data", rsp_data, 64'd0);

        // Wrap: grant 1 moves ptr to 2, then req=011 wraps to requester 0.
        do_reset();
        req = 3'b010;
        tick();
        req = 3'b011;
        tick();
        check("r032_rsp_valid", 64'(rsp_valid), 64'b001);

        // Reset mid-stream discards the grant.
        do_reset();
        req = 3'b111;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("r033_rsp_valid", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        tick();
        check("r033_first_gnt", 64'(rsp_valid), 64'b001);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 49) == 0);
            req   = 3'($urandom);
            for (int r = 0; r < NREQ; r++) req_addr[r] = 5'($urandom);
            rf[$urandom_range(0, 31)] = {$urandom, $urandom};
            tick();
        end
        reset = 1'b0;

        // Long two-way conflict: counter saturates, grants alternate.
        do_reset();
        req         = 3'b011;
        req_addr[0] = 5'd1;
        req_addr[1] = 5'd2;
        repeat (70000) tick();
        check("r034_cnt_sat", 64'(conflict_cnt), 64'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
